// File: rtl/load_store_unit_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states and register-file write-enable codes
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] RWE_NONE = 3'd0;
    localparam logic [2:0] RWE_WORD = 3'd1;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WB = 2'd2} state_t;
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: req/ack data-memory bus between the unit (master) and memory (slave)
interface load_store_unit_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    modport master (output req, we, be, addr, wdata, input ack, rdata);
    modport slave  (input req, we, be, addr, wdata, output ack, rdata);
endinterface

// File: rtl/load_store_unit_load_align.sv
// load_align: picks the addressed byte/half from a read word and sign/zero-extends it
module load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = rdata[8*off +: 8];
        h = rdata[16*off[1] +: 16];
        data = funct3 == F3_B  ? {{24{b[7]}}, b} :
               funct3 == F3_BU ? {24'd0, b} :
               funct3 == F3_H  ? {{16{h[15]}}, h} :
               funct3 == F3_HU ? {16'd0, h} : rdata;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-request memory stage with req/ack handshake, timeout and one-cycle writeback
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_load,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [4:0]         req_rd,
    load_store_unit_if.master  mem,
    output logic [31:0]        Data_D,
    output logic [4:0]         Addr_D,
    output logic [2:0]         rwe,
    output logic               stall,
    output logic               done,
    output logic               misalign_err,
    output logic               bus_err
);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic load_q, load_d, we_q, we_d;
    logic [2:0] f3_q, f3_d;
    logic [1:0] off_q, off_d;
    logic [4:0] rd_q, rd_d, waddr_q, waddr_d;
    logic [3:0] be_q, be_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d, data_q, data_d, aligned;
    logic rwe_q, rwe_d, done_q, done_d, mis_q, mis_d, berr_q, berr_d;
    logic accept, bad, unsup, ack, tmo;

    load_align u_align (.funct3(f3_q), .off(off_q), .rdata(mem.rdata), .data(aligned));

    always_comb begin
        accept = req_valid && state_q == IDLE;
        unsup = req_load ? !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                         : !(req_funct3 inside {F3_B, F3_H, F3_W});
        bad = unsup || (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
              (req_funct3 == F3_W && req_addr[1:0] != 2'b00);
        ack = mem.ack && state_q == ACCESS;
        // ack takes priority over a timeout landing in the same cycle
        tmo = state_q == ACCESS && !mem.ack && cnt_q == CNT_W'(TIMEOUT - 1);
        state_d = state_q == IDLE   ? (accept && !bad ? ACCESS : IDLE) :
                  state_q == ACCESS ? (ack ? (load_q ? WB : IDLE) : tmo ? IDLE : ACCESS) : IDLE;
        cnt_d = accept ? '0 : state_q == ACCESS ? cnt_q + 1'b1 : cnt_q;
        load_d = load_q;
        f3_d = f3_q;
        off_d = off_q;
        rd_d = rd_q;
        we_d = we_q;
        be_d = be_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            load_d = req_load;
            f3_d = req_funct3;
            off_d = req_addr[1:0];
            rd_d = req_rd;
            addr_d = req_addr[31:2];
            we_d = !req_load;
            be_d = req_load ? 4'b1111 :
                   req_funct3 == F3_B ? 4'b0001 << req_addr[1:0] :
                   req_funct3 == F3_H ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
            wdata_d = req_funct3 == F3_B ? {4{req_wdata[7:0]}} :
                      req_funct3 == F3_H ? {2{req_wdata[15:0]}} : req_wdata;
        end
        rwe_d = ack && load_q && rd_q != 5'd0;
        data_d = rwe_d ? aligned : data_q;
        waddr_d = rwe_d ? rd_q : waddr_q;
        done_d = ack;
        mis_d = accept && bad;
        berr_d = tmo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            load_q <= 1'b0;
            f3_q <= 3'd0;
            off_q <= 2'd0;
            rd_q <= 5'd0;
            we_q <= 1'b0;
            be_q <= 4'd0;
            addr_q <= '0;
            wdata_q <= '0;
            data_q <= '0;
            waddr_q <= 5'd0;
            rwe_q <= 1'b0;
            done_q <= 1'b0;
            mis_q <= 1'b0;
            berr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            load_q <= load_d;
            f3_q <= f3_d;
            off_q <= off_d;
            rd_q <= rd_d;
            we_q <= we_d;
            be_q <= be_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            data_q <= data_d;
            waddr_q <= waddr_d;
            rwe_q <= rwe_d;
            done_q <= done_d;
            mis_q <= mis_d;
            berr_q <= berr_d;
        end
    end

    assign req_ready = state_q == IDLE;
    assign stall = state_q != IDLE;
    assign mem.req = state_q == ACCESS;
    assign mem.we = mem.req && we_q;
    assign mem.be = mem.req ? be_q : 4'd0;
    assign mem.addr = mem.req ? {addr_q, 2'b00} : 32'd0;
    assign mem.wdata = mem.req ? wdata_q : 32'd0;
    assign Data_D = data_q;
    assign Addr_D = waddr_q;
    assign rwe = rwe_q ? RWE_WORD : RWE_NONE;
    assign done = done_q;
    assign misalign_err = mis_q;
    assign bus_err = berr_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with expected events queued and checked by a decoupled monitor
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct packed {
        logic rwe, done, mis, berr;
        logic [31:0] data;
        logic [4:0] addr;
    } ev_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0] be;
        logic we;
        logic [31:0] wd;
        logic cw;
    } mx_t;

    logic clk = 0, reset = 1;
    always #5 clk = ~clk;

    logic req_valid = 0, req_load = 0;
    logic [2:0] req_funct3 = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [4:0] req_rd = 0;
    logic req_ready, stall, done, misalign_err, bus_err;
    logic [31:0] Data_D;
    logic [4:0] Addr_D;
    logic [2:0] rwe;

    load_store_unit_if mem ();

    load_store_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .mem(mem), .Data_D(Data_D),
        .Addr_D(Addr_D), .rwe(rwe), .stall(stall), .done(done),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    int checks = 0, errors = 0, nstall = 0;
    ev_t evq[$];
    mx_t mq[$];
    logic req_prev = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endfunction

    function automatic ev_t ev(input logic r, d, mi, b, input logic [31:0] dt, input logic [4:0] ad);
        ev_t e;
        e.rwe = r; e.done = d; e.mis = mi; e.berr = b; e.data = dt; e.addr = ad;
        return e;
    endfunction

    function automatic mx_t mx(input logic [31:0] a, input logic [3:0] be, input logic we,
                               input logic [31:0] wd, input logic cw);
        mx_t m;
        m.addr = a; m.be = be; m.we = we; m.wd = wd; m.cw = cw;
        return m;
    endfunction

    always @(posedge clk) if (stall) nstall++;

    always @(negedge clk) begin
        if (!reset) begin
            if (rwe != 3'd0 || done || misalign_err || bus_err) begin
                if (evq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: rwe=%0d done=%0b mis=%0b berr=%0b, expected none",
                             rwe, done, misalign_err, bus_err);
                end else begin
                    ev_t e;
                    e = evq.pop_front();
                    chk("rwe", {29'd0, rwe}, e.rwe ? 32'd1 : 32'd0);
                    chk("done", {31'd0, done}, {31'd0, e.done});
                    chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
                    chk("bus_err", {31'd0, bus_err}, {31'd0, e.berr});
                    if (e.rwe) begin
                        chk("Data_D", Data_D, e.data);
                        chk("Addr_D", {27'd0, Addr_D}, {27'd0, e.addr});
                    end
                end
            end
            if (mem.req && !req_prev) begin
                if (mq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mem_req: addr=0x%08h, expected no access", mem.addr);
                end else begin
                    mx_t m;
                    m = mq.pop_front();
                    chk("mem_addr", mem.addr, m.addr);
                    chk("mem_be", {28'd0, mem.be}, {28'd0, m.be});
                    chk("mem_we", {31'd0, mem.we}, {31'd0, m.we});
                    if (m.cw) chk("mem_wdata", mem.wdata, m.wd);
                end
            end
        end
        req_prev = mem.req;
    end

    task automatic op(input string nm, input logic ld, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [4:0] rd, input int w, input logic [31:0] rdata,
                      input ev_t e, input logic has_mem, input mx_t m, input int exp_stall);
        int to;
        if (has_mem) mq.push_back(m);
        evq.push_back(e);
        @(negedge clk);
        nstall = 0;
        req_valid = 1; req_load = ld; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        @(negedge clk);
        req_valid = 0;
        if (has_mem && w >= 0) begin
            repeat (w) @(negedge clk);
            mem.ack = 1; mem.rdata = rdata;
            @(negedge clk);
            mem.ack = 0; mem.rdata = 32'h0;
        end
        to = 0;
        while (!req_ready && to < 40) begin
            @(negedge clk);
            to++;
        end
        if (to >= 40) begin
            checks++; errors++;
            $display("FAIL %s_ready_timeout: req_ready=0 after 40 cycles, expected 1", nm);
        end
        chk({nm, "_stall_cycles"}, nstall, exp_stall);
    endtask

    initial begin
        mem.ack = 0; mem.rdata = 0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_mem_req", {31'd0, mem.req}, 32'd0);
        chk("reset_rwe", {29'd0, rwe}, 32'd0);
        chk("reset_Data_D", Data_D, 32'd0);
        reset = 0;
        op("lb", 1, F3_B, 32'h102, 0, 5'd5, 2, 32'h11A23344, ev(1, 1, 0, 0, 32'hFFFFFFA2, 5'd5),
           1, mx(32'h100, 4'hF, 0, 0, 0), 4);
        op("lhu", 1, F3_HU, 32'h202, 0, 5'd6, 0, 32'h8001ABCD, ev(1, 1, 0, 0, 32'h00008001, 5'd6),
           1, mx(32'h200, 4'hF, 0, 0, 0), 2);
        op("lh", 1, F3_H, 32'h202, 0, 5'd6, 0, 32'h8001ABCD, ev(1, 1, 0, 0, 32'hFFFF8001, 5'd6),
           1, mx(32'h200, 4'hF, 0, 0, 0), 2);
        op("lbu", 1, F3_BU, 32'h101, 0, 5'd9, 1, 32'h11A23344, ev(1, 1, 0, 0, 32'h00000033, 5'd9),
           1, mx(32'h100, 4'hF, 0, 0, 0), 3);
        op("sb", 0, F3_B, 32'h303, 32'h000000EE, 5'd0, 1, 0, ev(0, 1, 0, 0, 0, 0),
           1, mx(32'h300, 4'b1000, 1, 32'hEEEEEEEE, 1), 2);
        op("sh", 0, F3_H, 32'h206, 32'h1234BEEF, 5'd0, 0, 0, ev(0, 1, 0, 0, 0, 0),
           1, mx(32'h204, 4'b1100, 1, 32'hBEEFBEEF, 1), 1);
        op("sw", 0, F3_W, 32'h40C, 32'hDEADBEEF, 5'd0, 3, 0, ev(0, 1, 0, 0, 0, 0),
           1, mx(32'h40C, 4'b1111, 1, 32'hDEADBEEF, 1), 4);
        op("lw_mis", 1, F3_W, 32'h401, 0, 5'd4, -1, 0, ev(0, 0, 1, 0, 0, 0), 0, mx(0, 0, 0, 0, 0), 0);
        op("lh_mis", 1, F3_H, 32'h203, 0, 5'd4, -1, 0, ev(0, 0, 1, 0, 0, 0), 0, mx(0, 0, 0, 0, 0), 0);
        op("st_f3", 0, F3_BU, 32'h500, 0, 5'd0, -1, 0, ev(0, 0, 1, 0, 0, 0), 0, mx(0, 0, 0, 0, 0), 0);
        op("tmo", 1, F3_W, 32'h700, 0, 5'd3, -1, 0, ev(0, 0, 0, 1, 0, 0),
           1, mx(32'h700, 4'hF, 0, 0, 0), 16);
        op("lw_rd0", 1, F3_W, 32'h500, 0, 5'd0, 0, 32'hCAFEF00D, ev(0, 1, 0, 0, 0, 0),
           1, mx(32'h500, 4'hF, 0, 0, 0), 2);
        op("lw", 1, F3_W, 32'h704, 0, 5'd31, 2, 32'h0BADF00D, ev(1, 1, 0, 0, 32'h0BADF00D, 5'd31),
           1, mx(32'h704, 4'hF, 0, 0, 0), 4);
        mq.push_back(mx(32'h600, 4'hF, 0, 0, 0));
        @(negedge clk);
        req_valid = 1; req_load = 1; req_funct3 = F3_W; req_addr = 32'h600; req_rd = 5'd7;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("rst_mid_mem_req", {31'd0, mem.req}, 32'd0);
        chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mid_rwe", {29'd0, rwe}, 32'd0);
        reset = 0; mem.ack = 1; mem.rdata = 32'h12345678;
        @(negedge clk);
        mem.ack = 0;
        repeat (2) @(negedge clk);
        op("post_rst_lhu", 1, F3_HU, 32'h60E, 0, 5'd12, 1, 32'h7FFF1234, ev(1, 1, 0, 0, 32'h00007FFF, 5'd12),
           1, mx(32'h60C, 4'hF, 0, 0, 0), 3);
        repeat (3) @(negedge clk);
        chk("ev_queue_empty", evq.size(), 0);
        chk("mem_queue_empty", mq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage that sits directly upstream of the register file write port.
- Takes one load or store request from execute and runs a req/ack handshake with data memory.
- Lane-aligns and extends load data, then drives the register file's Data_D/Addr_D/rwe for exactly one cycle.
- Asserts stall to the pipeline while an access is in flight.

Parameters:
- TIMEOUT, 16, max cycles mem_req may wait for mem_ack before aborting with bus_err.
- CNT_W, 5, width of the timeout counter (must hold TIMEOUT).

Ports:
- clk  in  1  clock; all logic updates on the rising edge.
- reset  in  1  reset; synchronous, active-high.
- req_valid  in  1  execute presents a memory op.
- req_ready  out  1  unit is in IDLE and accepts a request this cycle.
- req_load  in  1  1 = load, 0 = store.
- req_funct3  in  3  RISC-V funct3: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- req_addr  in  32  byte address (rs1 + imm).
- req_wdata  in  32  store data (rs2).
- req_rd  in  5  load destination register.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  store strobe.
- mem_be  out  4  byte enables.
- mem_addr  out  32  word-aligned address ({req_addr[31:2],2'b00}).
- mem_wdata  out  32  store data replicated into lanes.
- mem_ack  in  1  memory done; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read word.
- Data_D  out  32  writeback data to the register file.
- Addr_D  out  5  writeback register index.
- rwe  out  3  register write enable; this unit drives only 0 or 1 (full 32-bit write).
- stall  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a request retires normally.
- misalign_err  out  1  one-cycle pulse for a misaligned request.
- bus_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset: state=IDLE; every output 0 except req_ready=1. Counter and request registers are cleared.
- States:
  - IDLE: req_ready=1. If req_valid, latch all request fields.
    - If misaligned (half with addr[0]=1; word with addr[1:0]!=0; or unsupported funct3): pulse misalign_err next cycle, stay in IDLE, issue no memory access and no writeback.
    - Otherwise go to ACCESS.
  - ACCESS: mem_req=1; mem_addr/mem_we/mem_be/mem_wdata are held stable.
    - Counter increments each cycle.
    - mem_ack: load -> WB; store -> IDLE with done pulse.
    - Counter reaches TIMEOUT without ack: drop mem_req, pulse bus_err, go to IDLE, no writeback.
  - WB: one cycle. Data_D = extended data, Addr_D = rd, rwe = 1 (rwe = 0 if rd == 0). done pulses and the next state is IDLE.
- Latency: accept on cycle 0; mem_req high from cycle 1; ack on cycle k; rwe on cycle k+1; req_ready again on cycle k+2. Stores are ready on cycle k+1.
- Byte enables, where o = addr[1:0]:
  - sb: 1<<o, wdata = {4{wdata[7:0]}}.
  - sh: 0011 or 1100, wdata = {2{wdata[15:0]}}.
  - sw: 1111.
  - Loads: be = 1111, mem_we = 0.
- Load extraction: byte = rdata[8*o +: 8]; half = rdata[16*o[1] +: 16]. lb/lh sign-extend; lbu/lhu zero-extend; lw is the word unchanged.
- Extended data is registered on ack; Data_D is not combinationally dependent on mem_rdata.
- A mem_ack seen outside ACCESS is ignored.
- A req_valid seen outside IDLE is ignored; upstream must hold the request on stall.
- Timeout and ack in the same cycle: ack wins.
- Reset mid-access: return to IDLE immediately, drop mem_req, no writeback, no error pulse.
- rwe, done and both error outputs are single-cycle pulses. Data_D/Addr_D hold their last value when rwe = 0.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding IDLE/ACCESS/WB.
  - rwe codes RWE_NONE=0 and RWE_WORD=1.
- One natural sub-module, load_align: purely combinational (funct3, offset, rdata) -> 32-bit extended data. The unit registers its output.

Test Plan:
- lb from 0x102 with rdata=0x11A23344, ack after 2 cycles -> Data_D=0xFFFFFFA2, Addr_D=req_rd, rwe=1 for one cycle; stall high 4 cycles.
- lhu from 0x202 with rdata=0x8001ABCD, ack after 0 wait -> Data_D=0x00008001. The same access as lh -> Data_D=0xFFFF8001.
- sb to 0x303 with wdata=0x000000EE -> mem_be=1000, mem_wdata=0xEEEEEEEE, mem_addr=0x300, mem_we=1; no rwe; done pulse.
- lw from 0x401 -> misalign_err pulse, mem_req never asserted, rwe stays 0.
- Load with no ack for TIMEOUT=16 cycles -> bus_err on cycle 17, mem_req low, IDLE. Also: lw rd=0 with ack -> rwe=0, done=1.
- reset asserted during ACCESS -> next cycle mem_req=0, req_ready=1, no rwe; a late ack is ignored; the next request completes normally.
